aopb_reg_arbiter: RTL and testbench

- Shares the single always-on peripheral register-bus master port (`ext_ao_peripheral_req/resp`) of `x_heep_system` among NUM_REQ smart-peripheral controllers, e.g. the im2col SPC plus future SPCs.
- Round-robin arbitration; a grant is locked until the transaction completes.
- Optional watchdog aborts stalled transactions.
- Sits in the FPGA/ASIC wrapper between the SPC instances and `x_heep_system`.

---
 rtl/aopb_reg_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_aopb_reg_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aopb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// aopb_reg_arbiter
//
// Purpose:
//   Shares the single always-on peripheral register-bus master port of
//   x_heep_system among NUM_REQ smart-peripheral controllers. Arbitration is
//   round-robin and a grant is held until the transaction completes (ready),
//   the requester withdraws valid, or, when enabled, the watchdog expires.
//
// Optional feature macro:
//   AOPB_ARB_TIMEOUT_EN - when defined, a watchdog aborts a transaction that
//                         has not seen ready after TIMEOUT_CYCLES BUSY cycles.
//                         When undefined, timeout_int_o is tied low and BUSY
//                         waits indefinitely.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   spc_req_i      per-requester register requests
//   spc_rsp_o      per-requester responses (only the granted one is live)
//   aopb_req_o     request forwarded to x_heep_system
//   aopb_rsp_i     response from x_heep_system
//   grant_id_o     index of the current / most recent grant
//   busy_o         transaction in flight
//   timeout_int_o  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------

package aopb_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | nothing forwarded; pick next requester starting from rr_ptr
// BUSY  | granted request passed through; wait for ready / abort / timeout
module aopb_reg_arbiter
    import aopb_reg_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  reg_req_t                   spc_req_i [NUM_REQ],
    output reg_rsp_t                   spc_rsp_o [NUM_REQ],
    output reg_req_t                   aopb_req_o,
    input  reg_rsp_t                   aopb_rsp_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_int_o
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("aopb_reg_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] grant_inc;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic [IDW:0]   cand;
    logic           expire;

    // One extra bit on cand so rr_ptr + k cannot overflow before the modulo
    // fold; this keeps non-power-of-two NUM_REQ correct.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!pick_found && spc_req_i[cand[IDW-1:0]].valid) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
    end

    assign grant_inc = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef AOPB_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q;

    // Held at zero while IDLE, so it starts from zero on every BUSY entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wd_cnt_q <= '0;
        end else if (!aopb_rsp_i.ready) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end

    assign expire = (state_q == BUSY) && !aopb_rsp_i.ready &&
                    (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Outputs are decoded from state_q, so an async reset forces them to
    // their idle values immediately and the downstream sees valid drop.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        aopb_req_o    = '0;
        busy_o        = 1'b0;
        timeout_int_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            spc_rsp_o[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_o             = 1'b1;
                aopb_req_o         = spc_req_i[grant_q];
                spc_rsp_o[grant_q] = aopb_rsp_i;
                if (aopb_rsp_i.ready || !spc_req_i[grant_q].valid) begin
                    // completion or requester abort; ready beats expiry
                    state_d  = IDLE;
                    rr_ptr_d = grant_inc;
                end else if (expire) begin
                    aopb_req_o.valid   = 1'b0;
                    spc_rsp_o[grant_q] = '{rdata: 32'h0, error: 1'b1, ready: 1'b1};
                    timeout_int_o      = 1'b1;
                    state_d            = IDLE;
                    rr_ptr_d           = grant_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_aopb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aopb_reg_arbiter
//
// Purpose:
//   Self-checking bench for aopb_reg_arbiter. A two-requester instance runs a
//   cycle-by-cycle vector table (single request, contention) and hand-written
//   sequences (abort, watchdog or its absence, reset mid-transaction). A
//   three-requester instance checks rotating fairness.
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_aopb_reg_arbiter;
    import aopb_reg_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    reg_req_t   spc_req [2];
    reg_rsp_t   spc_rsp [2];
    reg_req_t   aopb_req;
    reg_rsp_t   aopb_rsp;
    logic [0:0] grant_id;
    logic       busy;
    logic       tint;

    reg_req_t   spc_req3 [3];
    reg_rsp_t   spc_rsp3 [3];
    reg_req_t   aopb_req3;
    reg_rsp_t   aopb_rsp3;
    logic [1:0] grant_id3;
    logic       busy3;
    logic       tint3;

    aopb_reg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .spc_req_i     (spc_req),
        .spc_rsp_o     (spc_rsp),
        .aopb_req_o    (aopb_req),
        .aopb_rsp_i    (aopb_rsp),
        .grant_id_o    (grant_id),
        .busy_o        (busy),
        .timeout_int_o (tint)
    );

    aopb_reg_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(8)) dut3 (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .spc_req_i     (spc_req3),
        .spc_rsp_o     (spc_rsp3),
        .aopb_req_o    (aopb_req3),
        .aopb_rsp_i    (aopb_rsp3),
        .grant_id_o    (grant_id3),
        .busy_o        (busy3),
        .timeout_int_o (tint3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic        wr1;
        logic        rdy;
        logic [31:0] rdata;
        logic        busy;
        logic        gnt;
        logic        avalid;
        logic [31:0] aaddr;
        logic [31:0] awdata;
        logic        r0rdy;
        logic        r1rdy;
        logic [31:0] r0data;
        logic [31:0] r1data;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic wr1,
                         input logic rdy, input logic [31:0] rdata);
        spc_req[0] = '{addr: 32'h0000_0020, write: 1'b0, wdata: 32'h0,
                       wstrb: 4'h0, valid: v0};
        spc_req[1] = '{addr: 32'h0000_0010, write: wr1, wdata: 32'hCAFE_0001,
                       wstrb: 4'hF, valid: v1};
        aopb_rsp   = '{rdata: rdata, error: 1'b0, ready: rdy};
    endtask

    function automatic vec_t mk(
        input logic v0, input logic v1, input logic wr1, input logic rdy,
        input logic [31:0] rdata, input logic eb, input logic eg, input logic ev,
        input logic [31:0] ea, input logic [31:0] ew, input logic e0r,
        input logic e1r, input logic [31:0] e0d, input logic [31:0] e1d);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.wr1 = wr1; v.rdy = rdy; v.rdata = rdata;
        v.busy = eb; v.gnt = eg; v.avalid = ev; v.aaddr = ea; v.awdata = ew;
        v.r0rdy = e0r; v.r1rdy = e1r; v.r0data = e0d; v.r1data = e1d;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int order [$];
        int nbusy;
        int bad;

        // single request on req1, ready on the 4th BUSY cycle
        vecs[0]  = mk(0,1,1,0,32'h0,  0,0,0,32'h00,32'h0,         0,0,32'h0, 32'h0);
        vecs[1]  = mk(0,1,1,0,32'h0,  1,1,1,32'h10,32'hCAFE_0001, 0,0,32'h0, 32'h0);
        vecs[2]  = mk(0,1,1,0,32'h0,  1,1,1,32'h10,32'hCAFE_0001, 0,0,32'h0, 32'h0);
        vecs[3]  = mk(0,1,1,0,32'h0,  1,1,1,32'h10,32'hCAFE_0001, 0,0,32'h0, 32'h0);
        vecs[4]  = mk(0,1,1,1,32'h0,  1,1,1,32'h10,32'hCAFE_0001, 0,1,32'h0, 32'h0);
        vecs[5]  = mk(0,0,0,0,32'h0,  0,1,0,32'h00,32'h0,         0,0,32'h0, 32'h0);
        // contention: rr_ptr wrapped to 0, so req0 first
        vecs[6]  = mk(1,1,0,0,32'h0,  0,1,0,32'h00,32'h0,         0,0,32'h0, 32'h0);
        vecs[7]  = mk(1,1,0,0,32'h0,  1,0,1,32'h20,32'h0,         0,0,32'h0, 32'h0);
        vecs[8]  = mk(1,1,0,1,32'h11, 1,0,1,32'h20,32'h0,         1,0,32'h11,32'h0);
        vecs[9]  = mk(0,1,0,0,32'h0,  0,0,0,32'h00,32'h0,         0,0,32'h0, 32'h0);
        vecs[10] = mk(0,1,0,1,32'h22, 1,1,1,32'h10,32'hCAFE_0001, 0,1,32'h0, 32'h22);
        vecs[11] = mk(0,0,0,0,32'h0,  0,1,0,32'h00,32'h0,         0,0,32'h0, 32'h0);

        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            spc_req3[i] = '0;
        end
        aopb_rsp3 = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_grant",  32'(grant_id), 32'h0);
        chk("rst_avalid", 32'(aopb_req.valid), 32'h0);
        chk("rst_aaddr",  aopb_req.addr, 32'h0);
        chk("rst_r0rdy",  32'(spc_rsp[0].ready), 32'h0);
        chk("rst_r1rdy",  32'(spc_rsp[1].ready), 32'h0);
        chk("rst_tint",   32'(tint), 32'h0);
        rst_ni = 1'b1;
        tick();

        // fairness: three requesters always valid, immediate ready
        for (int i = 0; i < 3; i++) begin
            spc_req3[i] = '{addr: 32'(i), write: 1'b0, wdata: 32'h0,
                            wstrb: 4'h0, valid: 1'b1};
        end
        aopb_rsp3 = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        nbusy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (busy3) begin
                nbusy++;
                order.push_back(int'(grant_id3));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            spc_req3[i].valid = 1'b0;
        end
        chk("fair_busy_cycles", 32'(nbusy), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_order%0d", k),
                (k < order.size()) ? 32'(order[k]) : 32'hFF, 32'(k % 3));
        end

        // table: single request and contention
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].v1, vecs[i].wr1, vecs[i].rdy, vecs[i].rdata);
            @(negedge clk_i);
            chk($sformatf("vec%0d_busy", i),   32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_grant", i),  32'(grant_id), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_avalid", i), 32'(aopb_req.valid), 32'(vecs[i].avalid));
            chk($sformatf("vec%0d_aaddr", i),  aopb_req.addr, vecs[i].aaddr);
            chk($sformatf("vec%0d_awdata", i), aopb_req.wdata, vecs[i].awdata);
            chk($sformatf("vec%0d_r0rdy", i),  32'(spc_rsp[0].ready), 32'(vecs[i].r0rdy));
            chk($sformatf("vec%0d_r1rdy", i),  32'(spc_rsp[1].ready), 32'(vecs[i].r1rdy));
            chk($sformatf("vec%0d_r0data", i), spc_rsp[0].rdata, vecs[i].r0data);
            chk($sformatf("vec%0d_r1data", i), spc_rsp[1].rdata, vecs[i].r1data);
            tick();
        end

        // abort: req0 drops valid in its third BUSY cycle, req1 pending
        drive(1, 1, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("abort_idle_busy", 32'(busy), 32'h0);
        tick();
        @(negedge clk_i);
        chk("abort_b1_grant",  32'(grant_id), 32'h0);
        chk("abort_b1_avalid", 32'(aopb_req.valid), 32'h1);
        tick();
        @(negedge clk_i);
        chk("abort_b2_avalid", 32'(aopb_req.valid), 32'h1);
        tick();
        drive(0, 1, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("abort_drop_avalid", 32'(aopb_req.valid), 32'h0);
        chk("abort_drop_busy",   32'(busy), 32'h1);
        tick();
        @(negedge clk_i);
        chk("abort_next_idle", 32'(busy), 32'h0);
        tick();
        @(negedge clk_i);
        chk("abort_req1_busy",  32'(busy), 32'h1);
        chk("abort_req1_grant", 32'(grant_id), 32'h1);
        drive(0, 1, 0, 1, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0);

        // stalled downstream on req0
        drive(1, 0, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("stall_idle_busy", 32'(busy), 32'h0);
        tick();
`ifdef AOPB_ARB_TIMEOUT_EN
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_i);
            chk($sformatf("wd_c%0d_r0rdy", n),  32'(spc_rsp[0].ready), 32'(n == 8));
            chk($sformatf("wd_c%0d_r0err", n),  32'(spc_rsp[0].error), 32'(n == 8));
            chk($sformatf("wd_c%0d_tint", n),   32'(tint), 32'(n == 8));
            chk($sformatf("wd_c%0d_avalid", n), 32'(aopb_req.valid), 32'(n != 8));
            tick();
        end
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("wd_after_tint", 32'(tint), 32'h0);
        chk("wd_after_busy", 32'(busy), 32'h0);
        tick();
        // ready on the expiry cycle: normal completion, no error, no pulse
        drive(1, 0, 0, 0, 32'h0);
        tick();
        for (int n = 1; n <= 8; n++) begin
            if (n == 8) begin
                drive(1, 0, 0, 1, 32'h55);
            end
            @(negedge clk_i);
            if (n == 8) begin
                chk("wd_race_r0rdy",  32'(spc_rsp[0].ready), 32'h1);
                chk("wd_race_r0err",  32'(spc_rsp[0].error), 32'h0);
                chk("wd_race_r0data", spc_rsp[0].rdata, 32'h55);
                chk("wd_race_tint",   32'(tint), 32'h0);
            end
            tick();
        end
        drive(0, 0, 0, 0, 32'h0);
`else
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (spc_rsp[0].ready || spc_rsp[1].ready || tint || !busy) begin
                bad++;
            end
            tick();
        end
        chk("nowd_bad_cycles", 32'(bad), 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("nowd_abort_avalid", 32'(aopb_req.valid), 32'h0);
        tick();
`endif

        // reset in the middle of a req1 transaction
        drive(0, 1, 0, 0, 32'h0);
        @(negedge clk_i);
        tick();
        @(negedge clk_i);
        chk("rmid_busy_before",  32'(busy), 32'h1);
        chk("rmid_grant_before", 32'(grant_id), 32'h1);
        tick();
        rst_ni = 1'b0;
        drive(1, 1, 0, 0, 32'h0);
        #1;
        chk("rmid_busy_async",   32'(busy), 32'h0);
        chk("rmid_avalid_async", 32'(aopb_req.valid), 32'h0);
        chk("rmid_grant_async",  32'(grant_id), 32'h0);
        chk("rmid_r1rdy_async",  32'(spc_rsp[1].ready), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        @(negedge clk_i);
        chk("rmid_regrant_busy",  32'(busy), 32'h1);
        chk("rmid_regrant_grant", 32'(grant_id), 32'h0);
        drive(1, 1, 0, 1, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk_i);
        chk("rmid_done_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
